// File: rtl/fetch_unit.sv
// fetch_unit: nanoLADA instruction fetch / PC stage with req/ready memory handshake,
// jump/branch next-PC selection, stall/halt control and a retired-instruction counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        sel_pc,
    input  logic        sel_addpc,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [10:0] reserved,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
    state_t state;
    logic [31:0] pc4, br_off, next_pc;
    always_comb begin
        pc4 = pc + 32'd4;
        br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc = sel_pc ? {pc4[31:28], instr[25:0], 2'b00} : sel_addpc ? pc4 + br_off : pc4;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_FETCH;
            pc <= {RESET_PC[31:2], 2'b00};
            instr <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_ready) begin
                    instr <= imem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: if (!stall) begin
                    pc <= next_pc;
                    retired <= retired + 32'd1;
                    state <= halt ? S_HALT : S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    // request is gated by rst_n so it drops the instant reset asserts
    assign imem_req = rst_n && state == S_FETCH;
    assign instr_valid = state == S_EXEC;
    assign halted = state == S_HALT;
    assign imem_addr = pc;
    assign opcode = instr[31:26];
    assign reserved = instr[10:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checking of fetch_unit against a behavioural model.
module tb_fetch_unit;
    logic        clk = 0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        sel_pc, sel_addpc, stall, halt;
    logic [31:0] pc, instr, retired;
    logic [5:0]  opcode;
    logic [10:0] reserved;
    logic        instr_valid, halted;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .sel_pc(sel_pc),
        .sel_addpc(sel_addpc), .stall(stall), .halt(halt), .pc(pc), .instr(instr),
        .opcode(opcode), .reserved(reserved), .instr_valid(instr_valid),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h5BD1_E995);
    endfunction

    function automatic logic [31:0] npc(input logic [31:0] p, input logic [31:0] ins,
                                        input logic sj, input logic sb);
        logic [31:0] sx;
        sx = {{16{ins[15]}}, ins[15:0]};
        if (sj) return ((p + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        if (sb) return p + 32'd4 + sx * 32'd4;
        return p + 32'd4;
    endfunction

    // model: m_st 0=fetching, 1=instruction held for execute, 2=halted
    int          m_st;
    logic [31:0] m_pc, m_instr, m_ret;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_st <= 0;
            m_pc <= 32'h0;
            m_instr <= 32'h0;
            m_ret <= 32'h0;
        end else if (m_st == 0) begin
            if (imem_ready) begin
                m_instr <= memf(m_pc);
                m_st <= 1;
            end
        end else if (m_st == 1 && !stall) begin
            m_pc <= npc(m_pc, m_instr, sel_pc, sel_addpc);
            m_ret <= m_ret + 32'd1;
            m_st <= halt ? 2 : 0;
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("imem_req", 32'(imem_req), 32'(rst_n && m_st == 0));
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("instr", instr, m_instr);
        chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
        chk("reserved", 32'(reserved), 32'(m_instr[10:0]));
        chk("instr_valid", 32'(instr_valid), 32'(m_st == 1));
        chk("halted", 32'(halted), 32'(m_st == 2));
        chk("retired", retired, m_ret);
    end

    task automatic drive_rd();
        imem_rdata = memf(imem_addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_rd();
    endtask

    initial begin
        int hcnt;
        rst_n = 0;
        imem_ready = 1;
        sel_pc = 0; sel_addpc = 0; stall = 0; halt = 0;
        mem[32'h0] = 32'h3421_0005;
        mem[32'h4] = 32'h0022_1820;
        mem[32'h10] = 32'h0800_0040;
        mem[32'h100] = 32'h0800_0040;
        mem[32'h200] = 32'h1000_FFFE;
        mem[32'h1FC] = 32'h0800_0010;
        mem[32'h44] = 32'h1000_FFED;
        imem_rdata = 32'h0;
        #2;
        chk("rst pc", pc, 32'h0);
        chk("rst req", 32'(imem_req), 32'h0);
        chk("rst retired", retired, 32'h0);
        chk("rst valid", 32'(instr_valid), 32'h0);
        @(posedge clk); #3;
        rst_n = 1;
        drive_rd();
        #1 chk("first addr", imem_addr, 32'h0);
        chk("first req", 32'(imem_req), 32'h1);
        step();
        chk("exec0 valid", 32'(instr_valid), 32'h1);
        chk("exec0 instr", instr, 32'h3421_0005);
        step(); chk("addr4", imem_addr, 32'h4);
        chk("fetch valid low", 32'(instr_valid), 32'h0);
        step(); chk("exec4 instr", instr, 32'h0022_1820);
        step(); chk("addr8", imem_addr, 32'h8);
        chk("retired2", retired, 32'd2);
        step(); step(); step(); step();
        chk("addr10", imem_addr, 32'h10);
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait req", 32'(imem_req), 32'h1);
            chk("wait addr", imem_addr, 32'h10);
        end
        imem_ready = 1;
        step(); chk("wait capture", instr, 32'h0800_0040);
        sel_pc = 1;
        step(); chk("jump 10", pc, 32'h100);
        step(); step(); chk("jump A", pc, 32'h100);
        sel_addpc = 1;
        step(); step(); chk("both C", pc, 32'h100);
        sel_addpc = 0;
        mem[32'h100] = 32'h0800_0080;
        drive_rd();
        step(); step(); chk("jump 200", pc, 32'h200);
        sel_pc = 0; sel_addpc = 1;
        step(); step(); chk("branch B", pc, 32'h1FC);
        sel_addpc = 0; sel_pc = 1;
        step(); step(); chk("jump 40", pc, 32'h40);
        sel_pc = 0;
        step();
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall pc", pc, 32'h40);
            chk("stall valid", 32'(instr_valid), 32'h1);
            chk("stall retired", retired, 32'd10);
        end
        stall = 0;
        step(); chk("post stall pc", pc, 32'h44);
        chk("post stall retired", retired, 32'd11);
        step(); sel_addpc = 1;
        step(); chk("branch to top", pc, 32'hFFFF_FFFC);
        sel_addpc = 0;
        step(); step(); chk("wrap pc", pc, 32'h0);
        step();
        halt = 1; stall = 1;
        step(); chk("halt held by stall", 32'(halted), 32'h0);
        stall = 0;
        step(); chk("halted", 32'(halted), 32'h1);
        chk("halt pc", pc, 32'h4);
        chk("halt retired", retired, 32'd14);
        halt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt req", 32'(imem_req), 32'h0);
            chk("halt pc hold", pc, 32'h4);
        end
        rst_n = 0;
        mem[32'h0] = 32'h0800_0020;
        #2 rst_n = 1;
        drive_rd();
        step(); sel_pc = 1;
        step(); chk("addr80", imem_addr, 32'h80);
        sel_pc = 0; imem_ready = 0;
        #2 rst_n = 0;
        #1 chk("async req", 32'(imem_req), 32'h0);
        chk("async pc", pc, 32'h0);
        chk("async retired", retired, 32'h0);
        imem_ready = 1;
        step(); step();
        #2 rst_n = 1;
        drive_rd();
        #1 chk("restart addr", imem_addr, 32'h0);
        chk("restart req", 32'(imem_req), 32'h1);
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            imem_ready = $urandom_range(0, 9) < 7;
            stall = $urandom_range(0, 9) < 3;
            sel_pc = $urandom_range(0, 9) < 2;
            sel_addpc = $urandom_range(0, 9) < 3;
            halt = $urandom_range(0, 99) < 3;
            hcnt = m_st == 2 ? hcnt + 1 : 0;
            if (hcnt > 3 || $urandom_range(0, 299) == 0) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
                drive_rd();
                hcnt = 0;
            end
        end
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
